// File: rtl/pipeline_pc_unit.sv
// IF-stage program counter: selects the next fetch address among sequential,
// branch, j/jal, jr and trap targets. It also handles halt/resume, holds
// redirects that arrive while halted, and flags misaligned jr targets.
// XLEN must be at least 32 so that the j/jal concatenation fits.
module pipeline_pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080),
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            PCWre_from_Control_Unit,
  input  logic            PCWre_from_Load_use_Detection_Unit,
  input  logic [1:0]      PCSrc,
  input  logic            JumpPCSrc,
  input  logic [XLEN-1:0] ID_PCadd4,
  input  logic [25:0]     ID_targetAddress,
  input  logic [XLEN-1:0] ID_ReadData1,
  input  logic [XLEN-1:0] MEM_BranchPC,
  input  logic            Resume,
  output logic [XLEN-1:0] currAddress,
  output logic [XLEN-1:0] nextPCAddress,
  output logic [XLEN-1:0] IF_PCadd4,
  output logic            Halted,
  output logic            RedirectPending,
  output logic            MisalignFault
);

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_TRAP   = 2'd3;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] seq_c;
  logic [XLEN-1:0] jump_c;
  logic [XLEN-1:0] target_c;
  logic            redirect_c;
  logic            jr_misalign_c;

  // The low bits of ID_PCadd4 are replaced by the j/jal index.
  logic unused_pcadd4_bits;
  assign unused_pcadd4_bits = ^ID_PCadd4[27:0];

  // Candidate targets. The sequential step wraps modulo 2^XLEN.
  assign seq_c         = pc_q + XLEN'(PC_STEP);
  assign jump_c        = {ID_PCadd4[XLEN-1:28], ID_targetAddress, 2'b00};
  assign redirect_c    = (PCSrc != SRC_SEQ);
  assign jr_misalign_c = (PCSrc == SRC_JUMP) && !JumpPCSrc &&
                         (ID_ReadData1[1:0] != 2'b00);

  // Select the redirect target. A misaligned jr is steered to the trap vector.
  always_comb begin
    target_c = seq_c;
    case (PCSrc)
      SRC_BRANCH: target_c = MEM_BranchPC;
      SRC_JUMP: begin
        if (JumpPCSrc)          target_c = jump_c;
        else if (jr_misalign_c) target_c = TRAP_VECTOR;
        else                    target_c = ID_ReadData1;
      end
      SRC_TRAP: target_c = TRAP_VECTOR;
      default:  target_c = seq_c;
    endcase
  end

  // Next-state and next-PC logic for the RUN/HALT sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    halted_d  = halted_q;
    fault_d   = fault_q | jr_misalign_c;
    case (state_q)
      RUN: begin
        if (!PCWre_from_Control_Unit) begin
          state_d  = HALT;
          halted_d = 1'b1;
          if (redirect_c) begin
            pend_pc_d = target_c;
            pend_d    = 1'b1;
          end
        end else if (redirect_c) begin
          // A redirect wins over a load-use stall.
          pc_d = target_c;
        end else if (PCWre_from_Load_use_Detection_Unit) begin
          pc_d = seq_c;
        end
      end
      HALT: begin
        // The last redirect seen while halted is the one kept.
        if (redirect_c) begin
          pend_pc_d = target_c;
          pend_d    = 1'b1;
        end
        if (Resume) begin
          state_d  = RUN;
          halted_d = 1'b0;
          pend_d   = 1'b0;
          if (redirect_c)  pc_d = target_c;
          else if (pend_q) pc_d = pend_pc_q;
        end
      end
      default: begin
        state_d  = RUN;
        halted_d = 1'b0;
      end
    endcase
  end

  // State registers. Reset is asynchronous and clears everything, including the sticky fault.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign currAddress     = pc_q;
  assign nextPCAddress   = pc_d;
  assign IF_PCadd4       = seq_c;
  assign Halted          = halted_q;
  assign RedirectPending = pend_q;
  assign MisalignFault   = fault_q;

endmodule

// File: tb/tb_pipeline_pc_unit.sv
// Scoreboard bench for pipeline_pc_unit: expected PCs are queued when stimulus is applied
// and popped after the clock edge that should produce them.
module tb_pipeline_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre_from_Control_Unit;
  logic        PCWre_from_Load_use_Detection_Unit;
  logic [1:0]  PCSrc;
  logic        JumpPCSrc;
  logic [31:0] ID_PCadd4;
  logic [25:0] ID_targetAddress;
  logic [31:0] ID_ReadData1;
  logic [31:0] MEM_BranchPC;
  logic        Resume;
  logic [31:0] currAddress;
  logic [31:0] nextPCAddress;
  logic [31:0] IF_PCadd4;
  logic        Halted;
  logic        RedirectPending;
  logic        MisalignFault;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  pipeline_pc_unit dut (
    .Clk                                (Clk),
    .Reset                              (Reset),
    .PCWre_from_Control_Unit            (PCWre_from_Control_Unit),
    .PCWre_from_Load_use_Detection_Unit (PCWre_from_Load_use_Detection_Unit),
    .PCSrc                              (PCSrc),
    .JumpPCSrc                          (JumpPCSrc),
    .ID_PCadd4                          (ID_PCadd4),
    .ID_targetAddress                   (ID_targetAddress),
    .ID_ReadData1                       (ID_ReadData1),
    .MEM_BranchPC                       (MEM_BranchPC),
    .Resume                             (Resume),
    .currAddress                        (currAddress),
    .nextPCAddress                      (nextPCAddress),
    .IF_PCadd4                          (IF_PCadd4),
    .Halted                             (Halted),
    .RedirectPending                    (RedirectPending),
    .MisalignFault                      (MisalignFault)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCWre_from_Control_Unit            = 1'b1;
    PCWre_from_Load_use_Detection_Unit = 1'b1;
    PCSrc            = 2'd0;
    JumpPCSrc        = 1'b0;
    ID_PCadd4        = 32'h0;
    ID_targetAddress = 26'h0;
    ID_ReadData1     = 32'h0;
    MEM_BranchPC     = 32'h0;
    Resume           = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 Reset = 1'b1;
    #1;
    checks++; if (currAddress !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", currAddress, 32'h0); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", Halted); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", RedirectPending); end
    checks++; if (MisalignFault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", MisalignFault); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++; if (nextPCAddress !== 32'h4) begin errors++; $display("FAIL reset_next: got %h want %h", nextPCAddress, 32'h4); end
    checks++; if (IF_PCadd4 !== 32'h4) begin errors++; $display("FAIL reset_pcadd4: got %h want %h", IF_PCadd4, 32'h4); end
  endtask

  task automatic test_sequential();
    exp_q.push_back(32'h4); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL seq_1: got %h want %h", currAddress, exp_pc); end
    exp_q.push_back(32'h8); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL seq_2: got %h want %h", currAddress, exp_pc); end
    PCSrc = 2'd1; MEM_BranchPC = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL preload: got %h want %h", currAddress, exp_pc); end
    idle_inputs();
    #1;
    checks++; if (IF_PCadd4 !== 32'h0) begin errors++; $display("FAIL wrap_pcadd4: got %h want %h", IF_PCadd4, 32'h0); end
    exp_q.push_back(32'h0); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL wrap_pc: got %h want %h", currAddress, exp_pc); end
  endtask

  task automatic test_branch_jump();
    PCSrc = 2'd1; MEM_BranchPC = 32'd100;
    exp_q.push_back(32'd100); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL branch: got %h want %h", currAddress, exp_pc); end
    PCSrc = 2'd2; JumpPCSrc = 1'b1; ID_PCadd4 = 32'h4; ID_targetAddress = 26'd2;
    exp_q.push_back(32'h8); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL jump_low: got %h want %h", currAddress, exp_pc); end
    ID_PCadd4 = 32'h3000_0004; ID_targetAddress = 26'h3FF_FFFF;
    exp_q.push_back(32'h3FFF_FFFC); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL jump_high: got %h want %h", currAddress, exp_pc); end
    idle_inputs();
  endtask

  task automatic test_jr();
    PCSrc = 2'd2; JumpPCSrc = 1'b0; ID_ReadData1 = 32'h20;
    exp_q.push_back(32'h20); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL jr_aligned: got %h want %h", currAddress, exp_pc); end
    checks++; if (MisalignFault !== 1'b0) begin errors++; $display("FAIL jr_no_fault: got %b want 0", MisalignFault); end
    ID_ReadData1 = 32'h22;
    exp_q.push_back(32'h80); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL jr_misalign_pc: got %h want %h", currAddress, exp_pc); end
    checks++; if (MisalignFault !== 1'b1) begin errors++; $display("FAIL jr_fault_set: got %b want 1", MisalignFault); end
    idle_inputs();
    exp_q.push_back(32'h84); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL after_trap: got %h want %h", currAddress, exp_pc); end
    checks++; if (MisalignFault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", MisalignFault); end
  endtask

  task automatic test_stall();
    PCWre_from_Load_use_Detection_Unit = 1'b0;
    #1;
    checks++; if (nextPCAddress !== 32'h84) begin errors++; $display("FAIL stall_next: got %h want %h", nextPCAddress, 32'h84); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h84); tick();
      exp_pc = exp_q.pop_front();
      checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL stall_hold_%0d: got %h want %h", i, currAddress, exp_pc); end
    end
    PCSrc = 2'd1; MEM_BranchPC = 32'h40;
    exp_q.push_back(32'h40); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL stall_redirect: got %h want %h", currAddress, exp_pc); end
    idle_inputs();
  endtask

  task automatic test_halt_resume();
    PCWre_from_Control_Unit = 1'b0;
    exp_q.push_back(32'h40); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL halt_hold: got %h want %h", currAddress, exp_pc); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", Halted); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL halt_no_pending: got %b want 0", RedirectPending); end
    // Stall is low here and must be ignored while halted.
    PCWre_from_Control_Unit = 1'b1; PCWre_from_Load_use_Detection_Unit = 1'b0;
    PCSrc = 2'd1; MEM_BranchPC = 32'h60;
    exp_q.push_back(32'h40); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL halt_redirect_hold: got %h want %h", currAddress, exp_pc); end
    checks++; if (RedirectPending !== 1'b1) begin errors++; $display("FAIL halt_pending: got %b want 1", RedirectPending); end
    idle_inputs();
    Resume = 1'b1;
    #1;
    checks++; if (nextPCAddress !== 32'h60) begin errors++; $display("FAIL resume_next: got %h want %h", nextPCAddress, 32'h60); end
    exp_q.push_back(32'h60); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL resume_pc: got %h want %h", currAddress, exp_pc); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b want 0", Halted); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL resume_pending: got %b want 0", RedirectPending); end
    idle_inputs();
  endtask

  task automatic test_back_to_back_redirects();
    PCWre_from_Control_Unit = 1'b0; PCSrc = 2'd1; MEM_BranchPC = 32'h200;
    exp_q.push_back(32'h60); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL halt_capture_hold: got %h want %h", currAddress, exp_pc); end
    checks++; if (RedirectPending !== 1'b1) begin errors++; $display("FAIL halt_capture_pending: got %b want 1", RedirectPending); end
    PCWre_from_Control_Unit = 1'b1; MEM_BranchPC = 32'h300;
    exp_q.push_back(32'h60); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL overwrite_hold: got %h want %h", currAddress, exp_pc); end
    Resume = 1'b1; MEM_BranchPC = 32'h400;
    exp_q.push_back(32'h400); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL resume_new_wins: got %h want %h", currAddress, exp_pc); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL resume_new_pending: got %b want 0", RedirectPending); end
    idle_inputs();
    PCWre_from_Control_Unit = 1'b0;
    exp_q.push_back(32'h400); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL halt2_hold: got %h want %h", currAddress, exp_pc); end
    PCWre_from_Control_Unit = 1'b1; Resume = 1'b1;
    exp_q.push_back(32'h400); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL resume_no_pending: got %h want %h", currAddress, exp_pc); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL resume2_halted: got %b want 0", Halted); end
    idle_inputs();
    exp_q.push_back(32'h404); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL run_after_resume: got %h want %h", currAddress, exp_pc); end
  endtask

  task automatic test_reset_mid_halt();
    PCWre_from_Control_Unit = 1'b0; PCSrc = 2'd1; MEM_BranchPC = 32'h500;
    exp_q.push_back(32'h404); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL pre_reset_hold: got %h want %h", currAddress, exp_pc); end
    checks++; if (RedirectPending !== 1'b1) begin errors++; $display("FAIL pre_reset_pending: got %b want 1", RedirectPending); end
    idle_inputs();
    #2 Reset = 1'b1;
    #1;
    checks++; if (currAddress !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h want %h", currAddress, 32'h0); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL async_reset_halted: got %b want 0", Halted); end
    checks++; if (RedirectPending !== 1'b0) begin errors++; $display("FAIL async_reset_pending: got %b want 0", RedirectPending); end
    checks++; if (MisalignFault !== 1'b0) begin errors++; $display("FAIL async_reset_fault: got %b want 0", MisalignFault); end
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.push_back(32'h4); tick();
    exp_pc = exp_q.pop_front();
    checks++; if (currAddress !== exp_pc) begin errors++; $display("FAIL post_reset_seq: got %h want %h", currAddress, exp_pc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0 entries", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_jr();
    test_stall();
    test_halt_resume();
    test_back_to_back_redirects();
    test_reset_mid_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
